// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes,
// mux selects and the control word. Also intended for use by the datapath and ALU control.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALUB_B          = 2'd0,
    ALUB_FOUR       = 2'd1,
    ALUB_SIGNIMM    = 2'd2,
    ALUB_SIGNIMM_SH = 2'd3
  } alusrcb_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2
  } aluop_t;

  typedef enum logic [1:0] {
    PCSRC_ALURESULT = 2'd0,
    PCSRC_ALUOUT    = 2'd1,
    PCSRC_JUMP      = 2'd2
  } pcsrc_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // pcwrite and branch are internal terms that combine into PCEn
  typedef struct packed {
    logic     pcwrite;
    logic     branch;
    logic     iord;
    logic     memread;
    logic     memwrite;
    logic     irwrite;
    logic     memtoreg;
    logic     regdst;
    logic     regwrite;
    logic     alusrca;
    alusrcb_t alusrcb;
    aluop_t   aluop;
    pcsrc_t   pcsrc;
  } ctrl_word_t;

endpackage

// File: rtl/mc_output_decode.sv
// Moore output decoder: maps the current FSM state to the control word.
// Only FETCH looks at memready, to qualify the instruction and PC writes.
module mc_output_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       memready,
  output ctrl_word_t cw
);

  // control word per state; anything not set stays 0
  always_comb begin
    cw = '0;
    case (state)
      S_FETCH: begin
        cw.memread = 1'b1;
        cw.alusrcb = ALUB_FOUR;
        cw.irwrite = memready;
        cw.pcwrite = memready;
      end
      S_DECODE: begin
        cw.alusrcb = ALUB_SIGNIMM_SH;
      end
      S_MEMADR: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = ALUB_SIGNIMM;
      end
      S_MEMRD: begin
        cw.memread = 1'b1;
        cw.iord    = 1'b1;
      end
      S_MEMWB: begin
        cw.regwrite = 1'b1;
        cw.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        cw.memwrite = 1'b1;
        cw.iord     = 1'b1;
      end
      S_EXECUTE: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = ALUB_B;
        cw.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        cw.regwrite = 1'b1;
        cw.regdst   = 1'b1;
      end
      S_BRANCH: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = ALUB_B;
        cw.aluop   = ALUOP_SUB;
        cw.pcsrc   = PCSRC_ALUOUT;
        cw.branch  = 1'b1;
      end
      S_ADDIEX: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = ALUB_SIGNIMM;
      end
      S_ADDIWB: begin
        cw.regwrite = 1'b1;
      end
      S_JUMP: begin
        cw.pcsrc   = PCSRC_JUMP;
        cw.pcwrite = 1'b1;
      end
      default: begin
        cw = '0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS main controller: state register, next-state logic and
// reset gating of the Moore control word produced by mc_output_decode.
module multicycle_controller
  import mips_ctrl_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [5:0] Opcode,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCEn,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic [3:0] State
);

  state_t     state_r;
  state_t     next_state_s;
  ctrl_word_t cw_s;
  ctrl_word_t gated_cw_s;

  mc_output_decode u_output_decode (
    .state    (state_r),
    .memready (MemReady),
    .cw       (cw_s)
  );

  // state register, the only storage in the block
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // next-state logic; Opcode is only looked at in DECODE and MEMADR
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_FETCH: begin
        if (MemReady) next_state_s = S_DECODE;
        else          next_state_s = S_FETCH;
      end
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: next_state_s = S_MEMADR;
          OP_RTYPE:     next_state_s = S_EXECUTE;
          OP_BEQ:       next_state_s = S_BRANCH;
          OP_ADDI:      next_state_s = S_ADDIEX;
          OP_J:         next_state_s = S_JUMP;
          default:      next_state_s = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (Opcode == OP_LW)      next_state_s = S_MEMRD;
        else if (Opcode == OP_SW) next_state_s = S_MEMWR;
        else                      next_state_s = S_FETCH;
      end
      S_MEMRD: begin
        if (MemReady) next_state_s = S_MEMWB;
        else          next_state_s = S_MEMRD;
      end
      S_MEMWR: begin
        if (MemReady) next_state_s = S_FETCH;
        else          next_state_s = S_MEMWR;
      end
      S_EXECUTE: next_state_s = S_ALUWB;
      S_ADDIEX:  next_state_s = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: next_state_s = S_FETCH;
      default:   next_state_s = S_FETCH;
    endcase
  end

  // outputs are forced low while reset is held, so FETCH's MemRead does not leak out
  always_comb begin
    if (Rst_n) gated_cw_s = cw_s;
    else       gated_cw_s = '0;
  end

  assign PCEn     = gated_cw_s.pcwrite | (gated_cw_s.branch & Zero);
  assign IorD     = gated_cw_s.iord;
  assign MemRead  = gated_cw_s.memread;
  assign MemWrite = gated_cw_s.memwrite;
  assign IRWrite  = gated_cw_s.irwrite;
  assign MemtoReg = gated_cw_s.memtoreg;
  assign RegDst   = gated_cw_s.regdst;
  assign RegWrite = gated_cw_s.regwrite;
  assign ALUSrcA  = gated_cw_s.alusrca;
  assign ALUSrcB  = gated_cw_s.alusrcb;
  assign ALUOp    = gated_cw_s.aluop;
  assign PCSrc    = gated_cw_s.pcsrc;
  assign State    = state_r;

endmodule
